// File: rtl/reg_bank.sv
// 16 x 16-bit general-purpose register file with two combinational read ports
// and one synchronous write port. There is no internal read-during-write bypass.
module reg_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rw,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] nReg1,
  input  logic [ADDR_W-1:0] nReg2,
  input  logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] reg1out,
  output logic [DATA_W-1:0] reg2out
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Only R[dest] may change on an edge; every other entry holds. R0 is an ordinary register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (rw) begin
      regs_d[dest] = dataIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign reg1out = regs_q[nReg1];
  assign reg2out = regs_q[nReg2];

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, hand-written reset
// sequences, and randomized traffic checked against an array-based model.
module tb_reg_bank;

  logic        clk;
  logic        rst_n;
  logic        rw;
  logic [15:0] dataIn;
  logic [3:0]  nReg1;
  logic [3:0]  nReg2;
  logic [3:0]  dest;
  logic [15:0] reg1out;
  logic [15:0] reg2out;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [16];

  typedef struct {
    logic        rw;
    logic [3:0]  dest;
    logic [15:0] data;
    logic [3:0]  n1;
    logic [3:0]  n2;
    logic [15:0] pre1;
    logic [15:0] pre2;
    logic [15:0] post1;
    logic [15:0] post2;
  } vec_t;

  vec_t vecs [4];

  reg_bank #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rw      (rw),
    .dataIn  (dataIn),
    .nReg1   (nReg1),
    .nReg2   (nReg2),
    .dest    (dest),
    .reg1out (reg1out),
    .reg2out (reg2out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one set of inputs half a cycle before the rising edge.
  task automatic apply_stimulus(input logic w, input logic [3:0] d, input logic [15:0] v,
                                input logic [3:0] a1, input logic [3:0] a2);
    @(negedge clk);
    rw     = w;
    dest   = d;
    dataIn = v;
    nReg1  = a1;
    nReg2  = a2;
    #1;
  endtask

  initial begin
    rst_n  = 1'b1;
    rw     = 1'b0;
    dest   = 4'd0;
    dataIn = 16'h0;
    nReg1  = 4'd2;
    nReg2  = 4'd3;

    vecs[0] = '{1'b1, 4'd1, 16'h0005, 4'd1, 4'd1, 16'h0000, 16'h0000, 16'h0005, 16'h0005};
    vecs[1] = '{1'b0, 4'd0, 16'h0000, 4'd2, 4'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 4'd1, 16'h0006, 4'd1, 4'd1, 16'h0005, 16'h0005, 16'h0006, 16'h0006};
    vecs[3] = '{1'b0, 4'd4, 16'hBEEF, 4'd4, 4'd1, 16'h0000, 16'h0006, 16'h0000, 16'h0006};

    // Reset held across several edges
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_r1", reg1out, 16'h0);
    check_output("reset_r2", reg2out, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_held_r1", reg1out, 16'h0);
    check_output("reset_held_r2", reg2out, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i].rw, vecs[i].dest, vecs[i].data, vecs[i].n1, vecs[i].n2);
      check_output($sformatf("vec%0d_pre_r1", i), reg1out, vecs[i].pre1);
      check_output($sformatf("vec%0d_pre_r2", i), reg2out, vecs[i].pre2);
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d_post_r1", i), reg1out, vecs[i].post1);
      check_output($sformatf("vec%0d_post_r2", i), reg2out, vecs[i].post2);
    end

    // Full sweep of every register, including R0
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 4'(i), 16'h1000 + 16'(i), 4'd0, 4'd0);
    end
    apply_stimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd15);
    for (int i = 0; i < 16; i++) begin
      nReg1 = 4'(i);
      nReg2 = 4'(15 - i);
      #1;
      check_output($sformatf("sweep%0d_r1", i), reg1out, 16'h1000 + 16'(i));
      check_output($sformatf("sweep%0d_r2", i), reg2out, 16'h100F - 16'(i));
    end

    // Reset pulse between edges clears everything without a clock edge
    apply_stimulus(1'b0, 4'd0, 16'h0, 4'd5, 4'd10);
    check_output("pulse_pre_r1", reg1out, 16'h1005);
    check_output("pulse_pre_r2", reg2out, 16'h100A);
    rst_n = 1'b0;
    #1;
    check_output("pulse_low_r1", reg1out, 16'h0);
    check_output("pulse_low_r2", reg2out, 16'h0);
    rst_n = 1'b1;
    #1;
    check_output("pulse_after_r1", reg1out, 16'h0);
    check_output("pulse_after_r2", reg2out, 16'h0);

    // Reset asserted just before an edge overrides the pending write
    apply_stimulus(1'b1, 4'd7, 16'h1234, 4'd7, 4'd0);
    @(posedge clk);
    #1;
    check_output("midrst_setup_r7", reg1out, 16'h1234);
    apply_stimulus(1'b1, 4'd7, 16'hFFFF, 4'd7, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_low_r1", reg1out, 16'h0);
    @(posedge clk);
    #1;
    check_output("midrst_edge_r1", reg1out, 16'h0);
    check_output("midrst_edge_r2", reg2out, 16'h0);
    @(negedge clk);
    rw = 1'b0;
    rst_n = 1'b1;
    #1;
    check_output("midrst_release_r7", reg1out, 16'h0);

    // Randomized traffic against an array model of the sixteen registers
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    for (int n = 0; n < 400; n++) begin
      logic        w;
      logic [3:0]  d;
      logic [15:0] v;
      logic [3:0]  a1;
      logic [3:0]  a2;
      w  = 1'($urandom_range(0, 1));
      d  = 4'($urandom_range(0, 15));
      v  = 16'($urandom);
      a1 = (n % 5 == 0) ? d : 4'($urandom_range(0, 15));
      a2 = (n % 7 == 0) ? a1 : 4'($urandom_range(0, 15));
      apply_stimulus(w, d, v, a1, a2);
      check_output("rand_pre_r1", reg1out, model[a1]);
      check_output("rand_pre_r2", reg2out, model[a2]);
      @(posedge clk);
      if (w) model[d] = v;
      #1;
      check_output("rand_post_r1", reg1out, model[a1]);
      check_output("rand_post_r2", reg2out, model[a2]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
